delay_line_reader: RTL and testbench
====================================

DELAY_LINE_READER -- requirements
Module: delay_line_reader

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, delay buffer address width (2**ADDR_BITS entries).
REQ-002 SHALL have parameter SAMPLE_BITS, default 12, unsigned offset-binary sample width.
REQ-003 SHALL have parameter FRAC_BITS, default 4, fractional delay width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port sample_strobe  in  1  one-cycle request to produce one tap sample.
REQ-007 SHALL have port wr_ptr  in  ADDR_BITS  buffer address most recently written by the delay-line writer.
REQ-008 SHALL have port delay  in  ADDR_BITS+FRAC_BITS  tap delay, unsigned fixed point: upper ADDR_BITS integer, lower FRAC_BITS fraction.
REQ-009 SHALL have port ram_re  out  1  buffer read enable.
REQ-010 SHALL have port ram_raddr  out  ADDR_BITS  buffer read address.
REQ-011 SHALL have port ram_rdata  in  SAMPLE_BITS  buffer read data, valid the cycle after the edge sampling ram_re/ram_raddr (registered-read RAM).
REQ-012 SHALL have port dout  out  SAMPLE_BITS  interpolated tap sample, held until next result.
REQ-013 SHALL have port dout_valid  out  1  one-cycle pulse when dout updates.
REQ-014 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, RD_A, RD_B, CAP_B, CALC; all other transitions to IDLE.
REQ-016 In IDLE with sample_strobe high: latch wr_ptr and delay, register ram_re=1, ram_raddr=addr_a, go RD_A.
REQ-017 addr_a SHALL be (wr_ptr - delay_int) mod 2**ADDR_BITS; addr_b SHALL be (addr_a - 1) mod 2**ADDR_BITS.
REQ-018 RD_A SHALL register ram_raddr=addr_b, ram_re=1, go RD_B; RD_B SHALL capture a=ram_rdata, go CAP_B.
REQ-019 CAP_B SHALL capture b=ram_rdata, drive ram_re=0, go CALC; CALC SHALL register dout, pulse dout_valid, go IDLE.
REQ-020 dout_valid SHALL assert exactly 4 clk cycles after the edge that accepted sample_strobe; throughput one request per 5 cycles.
REQ-021 sample_strobe while busy (including the CALC cycle) SHALL be ignored, not queued; latched inputs SHALL not change mid-operation.
REQ-022 dout SHALL equal a + floor(((b - a) * frac) / 2**FRAC_BITS), difference signed SAMPLE_BITS+1 bits, product signed SAMPLE_BITS+FRAC_BITS+2 bits, arithmetic right shift.
REQ-023 Result SHALL lie within [min(a,b), max(a,b)]; no saturation logic required; truncation to SAMPLE_BITS lossless.
REQ-024 delay_int = 2**ADDR_BITS-1 SHALL force frac to 0 (addr_b would alias newest sample).
REQ-025 frac = 0 SHALL still perform both reads; dout = a.

Reset
REQ-026 rst SHALL force state IDLE, dout=0, dout_valid=0, ram_re=0, ram_raddr=0, busy=0, latched a/b/wr_ptr/delay=0.
REQ-027 rst mid-operation SHALL abort with no dout_valid pulse; a strobe coincident with rst SHALL be ignored.

Structure
REQ-028 FSM state encodings and default ADDR_BITS/SAMPLE_BITS/FRAC_BITS constants SHALL live in shared package delay_line_pkg, also used by the delay-line writer.
REQ-029 The interpolation arithmetic SHALL be a sub-module delay_interp (combinational: a, b, frac -> y), registered by the CALC state.

Verification (ADDR_BITS=8, SAMPLE_BITS=12, FRAC_BITS=4, RAM model with one-cycle read latency)
REQ-030 mem[i]=16*i, wr_ptr=100, delay=0x0A0 -> reads addr 90 then 89, dout=1440, dout_valid 4 cycles after strobe, single pulse.
REQ-031 mem[90]=1000, mem[89]=2000: delay 0x0A8 -> 1500; 0x0A4 -> 1250; swapped contents, 0x0A4 -> 1750; mem[90]=10, mem[89]=5, 0x0A1 -> 9 (floor).
REQ-032 wr_ptr=3, delay=0x050 -> ram_raddr 254 then 253 (wrap); delay=0xFFF, wr_ptr=10 -> addr 11 then 10, dout=mem[11].
REQ-033 Strobes at accept cycle +1..+4 -> ignored, exactly one dout_valid; strobe at +5 -> accepted, second result at +9.
REQ-034 rst asserted in RD_B -> next cycle all outputs 0, state IDLE, no dout_valid; subsequent strobe -> normal result.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared definitions for the delay-line reader and writer: default widths
// and the reader FSM state encoding.
package delay_line_pkg;

  localparam int DEF_ADDR_BITS   = 8;
  localparam int DEF_SAMPLE_BITS = 12;
  localparam int DEF_FRAC_BITS   = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    CAP_B = 3'd3,
    CALC  = 3'd4
  } state_e;

endpackage

// File: rtl/delay_line_reader_if.sv
// Read bus between the delay-line reader and its registered-read buffer RAM.
// The reader is the master; the RAM (or a RAM model) is the slave.
interface delay_line_reader_if
  import delay_line_pkg::*;
#(
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS
);

  logic                   ram_re;
  logic [ADDR_BITS-1:0]   ram_raddr;
  logic [SAMPLE_BITS-1:0] ram_rdata;

  modport master (
    output ram_re,
    output ram_raddr,
    input  ram_rdata
  );

  modport slave (
    input  ram_re,
    input  ram_raddr,
    output ram_rdata
  );

endinterface

// File: rtl/delay_interp.sv
// Linear interpolation between two offset-binary samples:
//   y = a + floor(((b - a) * frac) / 2**FRAC_BITS)
// Purely combinational; the caller registers the result.
module delay_interp
  import delay_line_pkg::*;
#(
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int FRAC_BITS   = DEF_FRAC_BITS
) (
  input  logic [SAMPLE_BITS-1:0] a,
  input  logic [SAMPLE_BITS-1:0] b,
  input  logic [FRAC_BITS-1:0]   frac,
  output logic [SAMPLE_BITS-1:0] y
);

  localparam int DW = SAMPLE_BITS + 1;
  localparam int PW = SAMPLE_BITS + FRAC_BITS + 2;

  logic signed [DW-1:0] diff;
  logic signed [PW-1:0] diff_ext;
  logic signed [PW-1:0] frac_ext;
  logic signed [PW-1:0] prod;

  // Signed difference, scaled by the fraction, floored by an arithmetic
  // shift. The result always lies between a and b, so truncating back to
  // SAMPLE_BITS loses nothing.
  always_comb begin
    diff     = $signed({1'b0, b}) - $signed({1'b0, a});
    diff_ext = {{(PW-DW){diff[DW-1]}}, diff};
    frac_ext = $signed({{(PW-FRAC_BITS){1'b0}}, frac});
    prod     = diff_ext * frac_ext;
    y        = SAMPLE_BITS'({{(PW-SAMPLE_BITS){1'b0}}, a} + $unsigned(prod >>> FRAC_BITS));
  end

endmodule

// File: rtl/delay_line_reader.sv
// Fractional-delay tap reader. On a request it reads the two buffer entries
// straddling the requested delay (newer sample a, one-older sample b) from a
// registered-read RAM and outputs their linear interpolation.
//
// Handshake: sample_strobe is a one-cycle request, accepted only when busy is
// low (strobes while busy, including the CALC cycle, are dropped, never
// queued). wr_ptr/delay are latched on acceptance. ram_re/ram_raddr are
// registered; ram_rdata is valid the cycle after the edge that samples them.
// dout_valid pulses for one cycle exactly 4 cycles after the accepting edge,
// and dout holds until the next result.
module delay_line_reader
  import delay_line_pkg::*;
#(
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int FRAC_BITS   = DEF_FRAC_BITS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_strobe,
  input  logic [ADDR_BITS-1:0]           wr_ptr,
  input  logic [ADDR_BITS+FRAC_BITS-1:0] delay,
  output logic                           ram_re,
  output logic [ADDR_BITS-1:0]           ram_raddr,
  input  logic [SAMPLE_BITS-1:0]         ram_rdata,
  output logic [SAMPLE_BITS-1:0]         dout,
  output logic                           dout_valid,
  output logic                           busy,
  output state_e                         dbg_state
);

  localparam int DLW = ADDR_BITS + FRAC_BITS;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
  logic [DLW-1:0]         delay_q, delay_d;
  logic [SAMPLE_BITS-1:0] a_q, a_d;
  logic [SAMPLE_BITS-1:0] b_q, b_d;
  logic                   ram_re_q, ram_re_d;
  logic [ADDR_BITS-1:0]   ram_raddr_q, ram_raddr_d;
  logic [SAMPLE_BITS-1:0] dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;

  logic [ADDR_BITS-1:0]   in_addr_a;
  logic [ADDR_BITS-1:0]   lat_int;
  logic [ADDR_BITS-1:0]   lat_addr_b;
  logic [FRAC_BITS-1:0]   lat_frac;
  logic [SAMPLE_BITS-1:0] interp_y;

  // Address arithmetic: addr_a from the live inputs (used on acceptance),
  // addr_b and the effective fraction from the latched copies. At the
  // maximum integer delay addr_b would alias the newest sample, so the
  // fraction is forced to zero there.
  always_comb begin
    in_addr_a  = wr_ptr - delay[DLW-1:FRAC_BITS];
    lat_int    = delay_q[DLW-1:FRAC_BITS];
    lat_addr_b = ptr_q - lat_int - {{(ADDR_BITS-1){1'b0}}, 1'b1};
    lat_frac   = (lat_int == {ADDR_BITS{1'b1}}) ? {FRAC_BITS{1'b0}} : delay_q[FRAC_BITS-1:0];
  end

  delay_interp #(
    .SAMPLE_BITS (SAMPLE_BITS),
    .FRAC_BITS   (FRAC_BITS)
  ) u_interp (
    .a    (a_q),
    .b    (b_q),
    .frac (lat_frac),
    .y    (interp_y)
  );

  // State register and datapath registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      delay_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      ram_re_q     <= 1'b0;
      ram_raddr_q  <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      delay_q      <= delay_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ram_re_q     <= ram_re_d;
      ram_raddr_q  <= ram_raddr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Next-state logic: fixed five-cycle sequence once a request is accepted.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = sample_strobe ? RD_A : IDLE;
      RD_A:    state_d = RD_B;
      RD_B:    state_d = CAP_B;
      CAP_B:   state_d = CALC;
      CALC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state datapath updates: issue the two reads, capture their data,
  // then register the interpolated result with a one-cycle valid pulse.
  always_comb begin
    ptr_d        = ptr_q;
    delay_d      = delay_q;
    a_d          = a_q;
    b_d          = b_q;
    ram_re_d     = 1'b0;
    ram_raddr_d  = ram_raddr_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_strobe) begin
          ptr_d       = wr_ptr;
          delay_d     = delay;
          ram_re_d    = 1'b1;
          ram_raddr_d = in_addr_a;
        end
      end
      RD_A: begin
        ram_re_d    = 1'b1;
        ram_raddr_d = lat_addr_b;
      end
      RD_B:  a_d = ram_rdata;
      CAP_B: b_d = ram_rdata;
      CALC: begin
        dout_d       = interp_y;
        dout_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign ram_re     = ram_re_q;
  assign ram_raddr  = ram_raddr_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_delay_line_reader.sv
// Bench for delay_line_reader: registered-read RAM model, directed cases,
// randomized requests, and a queue-based scoreboard fed by a reference model.
module tb_delay_line_reader;
  import delay_line_pkg::*;

  localparam int AB = 8;
  localparam int SB = 12;
  localparam int FB = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_strobe = 1'b0;
  logic [AB-1:0] wr_ptr = '0;
  logic [AB+FB-1:0] delay = '0;
  logic [SB-1:0] dout;
  logic          dout_valid;
  logic          busy;
  state_e        dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  delay_line_reader_if #(.ADDR_BITS(AB), .SAMPLE_BITS(SB)) bus ();

  delay_line_reader #(
    .ADDR_BITS   (AB),
    .SAMPLE_BITS (SB),
    .FRAC_BITS   (FB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_strobe (sample_strobe),
    .wr_ptr        (wr_ptr),
    .delay         (delay),
    .ram_re        (bus.ram_re),
    .ram_raddr     (bus.ram_raddr),
    .ram_rdata     (bus.ram_rdata),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // Registered-read RAM model: one cycle of read latency.
  logic [SB-1:0] mem [256];
  always @(posedge clk) if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_raddr];

  // ---------------- scoreboard state ----------------
  logic [SB-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [AB-1:0] exp_addr_q[$];
  int checks = 0;
  int failures = 0;
  int next_free = 0;
  int last_accept = -100;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: integer/fraction split, modular addresses, floored
  // linear interpolation with plain integer arithmetic.
  task automatic ref_model(input int wr, input int dl, output int aa, output int bb, output int y);
    int di, fr, a, b, t, q;
    di = dl / 16;
    fr = dl % 16;
    if (di == 255) fr = 0;
    aa = (wr - di + 256) % 256;
    bb = (aa + 255) % 256;
    a  = int'(mem[aa]);
    b  = int'(mem[bb]);
    t  = (b - a) * fr;
    q  = t / 16;
    if (t < 0 && (t % 16) != 0) q = q - 1;
    y  = a + q;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents one strobe for one edge. If the model says it will be accepted,
  // the expected reads, result and result cycle are queued.
  task automatic issue(input int wr, input int dl, input bit use_exp, input int exp_v);
    int e, aa, bb, y;
    logic [SB-1:0] ev;
    @(negedge clk);
    sample_strobe = 1'b1;
    wr_ptr = wr[AB-1:0];
    delay  = dl[AB+FB-1:0];
    e = cyc + 1;
    if (!rst && e >= next_free) begin
      ref_model(wr, dl, aa, bb, y);
      ev = use_exp ? exp_v[SB-1:0] : y[SB-1:0];
      exp_q.push_back(ev);
      exp_cyc_q.push_back(e + 4);
      exp_addr_q.push_back(aa[AB-1:0]);
      exp_addr_q.push_back(bb[AB-1:0]);
      next_free = e + 5;
      last_accept = e;
    end
    @(posedge clk);
    #1 sample_strobe = 1'b0;
  endtask

  // Applies reset (optionally with a coincident strobe) and checks that every
  // output is back at its reset value.
  task automatic do_reset(input bit with_strobe);
    @(negedge clk);
    rst = 1'b1;
    if (with_strobe) begin
      sample_strobe = 1'b1;
      wr_ptr = 8'd100;
      delay  = 12'h0A0;
    end
    exp_q.delete();
    exp_cyc_q.delete();
    next_free = 0;
    @(posedge clk);
    last_accept = -100;
    #1 sample_strobe = 1'b0;
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_ram_re", int'(bus.ram_re), 0);
    chk("rst_ram_raddr", int'(bus.ram_raddr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_state", int'(dbg_state), int'(IDLE));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) chk("busy", int'(busy), int'(cyc >= last_accept && cyc <= last_accept + 3));
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_dout_valid: got dout=%0d expected no pulse (cycle %0d)", dout, cyc);
        end else begin
          chk("dout", int'(dout), int'(exp_q.pop_front()));
          chk("dout_valid_cycle", cyc, exp_cyc_q.pop_front());
        end
      end
      if (bus.ram_re) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read: got addr=%0d expected no read (cycle %0d)", bus.ram_raddr, cyc);
        end else begin
          chk("ram_raddr", int'(bus.ram_raddr), int'(exp_addr_q.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = SB'(16 * i);
    do_reset(1'b0);

    // Basic tap: reads 90 then 89, result 1440.
    issue(100, 'h0A0, 1'b1, 1440);
    idle(6);

    // Interpolation fractions and floor behaviour.
    mem[90] = 12'd1000; mem[89] = 12'd2000;
    issue(100, 'h0A8, 1'b1, 1500);
    idle(6);
    issue(100, 'h0A4, 1'b1, 1250);
    idle(6);
    mem[90] = 12'd2000; mem[89] = 12'd1000;
    issue(100, 'h0A4, 1'b1, 1750);
    idle(6);
    mem[90] = 12'd10; mem[89] = 12'd5;
    issue(100, 'h0A1, 1'b1, 9);
    idle(6);

    // Address wrap and maximum integer delay (fraction forced to zero).
    for (int i = 0; i < 256; i++) mem[i] = SB'(16 * i);
    issue(3, 'h050, 1'b1, 4064);
    idle(6);
    issue(10, 'hFFF, 1'b1, 176);
    idle(6);

    // Strobes while busy are dropped; the one at +5 is accepted.
    issue(100, 'h0A0, 1'b1, 1440);
    for (int k = 0; k < 4; k++) issue($urandom_range(0, 255), $urandom_range(0, 4095), 1'b0, 0);
    issue(20, 'h033, 1'b0, 0);
    idle(6);

    // Reset while in RD_B aborts without a result; normal operation resumes.
    issue(100, 'h0A0, 1'b1, 1440);
    idle(1);
    do_reset(1'b0);
    idle(8);
    issue(100, 'h0A0, 1'b1, 1440);
    idle(6);

    // Strobe coincident with reset is ignored.
    do_reset(1'b1);
    idle(8);

    // Randomized requests against random buffer contents.
    for (int i = 0; i < 256; i++) mem[i] = SB'($urandom_range(0, 4095));
    for (int n = 0; n < 80; n++) begin
      int sel, dl;
      idle($urandom_range(0, 6));
      sel = $urandom_range(0, 9);
      if (sel == 0)      dl = 'hFF0 | $urandom_range(0, 15);
      else if (sel == 1) dl = $urandom_range(0, 255) * 16;
      else               dl = $urandom_range(0, 4095);
      issue($urandom_range(0, 255), dl, 1'b0, 0);
    end

    idle(12);
    chk("pending_results", exp_q.size(), 0);
    chk("pending_reads", exp_addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
